shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares one combinational barrel shifter between two requesters (e.g. execute
//  stage and load/store byte-align logic) using round-robin arbitration.
//  Drives the shifter operands from the granted request and registers the
//  shifter result into a single-entry response buffer.
//  Responses carry a requester ID and a pass-through tag, with valid/ready
//  flow control on both sides.
// PARAMETERS
//  WIDTH   32   data width of operand and result
//  SHW     5    shift-amount width; equals $clog2(WIDTH)
//  TAGW    4    width of the opaque tag returned with each response
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req0_valid   in   1      requester 0 has a shift request
//  req0_ready   out  1      requester 0 request accepted this cycle
//  req0_a       in   WIDTH  operand to shift
//  req0_shamt   in   SHW    shift amount
//  req0_type    in   2      00=SLL, 01=SRL, 10=SRA, 11=reserved
//  req0_tag     in   TAGW   opaque tag, returned unchanged
//  req1_*       same as req0_* for requester 1
//  shf_a        out  WIDTH  operand to shared shifter
//  shf_shamt    out  SHW    shift amount to shared shifter
//  shf_type     out  2      shift type to shared shifter
//  shf_r        in   WIDTH  combinational shifter result
//  rsp_valid    out  1      response buffer holds a result
//  rsp_ready    in   1      consumer takes the response this cycle
//  rsp_r        out  WIDTH  shift result
//  rsp_id       out  1      requester that issued the result (0/1)
//  rsp_tag      out  TAGW   tag of the originating request
// BEHAVIOUR
//  - Reset (async, immediate):
//    - rsp_valid=0, rsp_r=0, rsp_id=0, rsp_tag=0.
//    - Priority pointer prio=0, so requester 0 wins the first tie.
//    - Any buffered response is discarded.
//  - can_accept = !rsp_valid | rsp_ready. The buffer drains and refills in the
//    same cycle, giving 1 result/cycle throughput.
//  - Grant (combinational):
//    - Only one requester valid: that requester.
//    - Both valid: requester == prio.
//    - None valid: no grant.
//  - reqN_ready = can_accept & grantN. At most one ready is high per cycle.
//    Ready may depend on reqN_valid; requesters must not make valid depend on ready.
//  - Shifter drive (combinational):
//    - With a grant: shf_* = granted req a/shamt/type.
//    - Without a grant: shf_a=0, shf_shamt=0, shf_type=00.
//  - Accept (reqN_valid & reqN_ready) at edge k: the buffer loads
//    rsp_r=shf_r, rsp_id=N, rsp_tag=reqN_tag. rsp_valid=1 from edge k; result
//    visible in the cycle after acceptance (latency 1).
//  - On each accept, prio <= ~N (the other requester gets next tie). No accept
//    means prio is unchanged.
//  - Backpressure: rsp_valid & !rsp_ready holds rsp_* stable and forces both
//    req ready low; pending requests wait with no loss and no reordering.
//  - Drain without refill (rsp_ready=1, no grant): rsp_valid <= 0. rsp_r, id and
//    tag keep their last values.
//  - type=11 is passed through unchanged; the shifter returns 0, so rsp_r=0.
//    No error is flagged.
//  - shamt is used modulo WIDTH by width; no saturation.
//  - Requesters must hold valid and operands stable until ready (standard
//    valid/ready). A request withdrawn before ready is simply never granted.
// TESTING
//  1. req0 a=0x8000_0001, shamt=4, type=00; rsp_ready=1
//     -> next cycle rsp_valid=1, rsp_r=0x0000_0010, id=0.
//  2. req1 a=0x8000_0000, shamt=31, type=10, tag=0xA
//     -> rsp_r=0xFFFF_FFFF, id=1, tag=0xA. SRL of same -> 0x0000_0001.
//  3. Both valid continuously after reset, rsp_ready=1
//     -> ids 0,1,0,1,... one response per cycle.
//  4. rsp_ready=0 for 3 cycles with both valid
//     -> rsp_* stable, req0/1_ready=0.
//     Then rsp_ready=1 -> same cycle one ready=1 and buffer refills.
//  5. type=11, a=0xFFFF_FFFF -> rsp_r=0x0000_0000.
//  6. Assert rst mid-cycle with rsp_valid=1
//     -> rsp_valid=0 immediately (before clock edge).
//     After release, first tie goes to requester 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external barrel shifter between two requesters,
// with a single-entry registered response buffer and valid/ready on both sides.
module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [1:0]       req0_type,
    input  logic [TAGW-1:0]  req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [1:0]       req1_type,
    input  logic [TAGW-1:0]  req1_tag,

    output logic [WIDTH-1:0] shf_a,
    output logic [SHW-1:0]   shf_shamt,
    output logic [1:0]       shf_type,
    input  logic [WIDTH-1:0] shf_r,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_id,
    output logic [TAGW-1:0]  rsp_tag
);

    logic prio;
    logic can_accept;
    logic grant0;
    logic grant1;
    logic acc0;
    logic acc1;

    // Buffer can be refilled in the same cycle it drains: full throughput.
    assign can_accept = !rsp_valid || rsp_ready;

    assign grant0 = req0_valid && (!req1_valid || !prio);
    assign grant1 = req1_valid && (!req0_valid ||  prio);

    assign req0_ready = can_accept && grant0;
    assign req1_ready = can_accept && grant1;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    always_comb begin
        shf_a     = '0;
        shf_shamt = '0;
        shf_type  = 2'b00;
        if (grant0) begin
            shf_a     = req0_a;
            shf_shamt = req0_shamt;
            shf_type  = req0_type;
        end else if (grant1) begin
            shf_a     = req1_a;
            shf_shamt = req1_shamt;
            shf_type  = req1_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_id    <= 1'b0;
            rsp_tag   <= '0;
            prio      <= 1'b0;
        end else if (can_accept) begin
            if (acc0) begin
                rsp_valid <= 1'b1;
                rsp_r     <= shf_r;
                rsp_id    <= 1'b0;
                rsp_tag   <= req0_tag;
                prio      <= 1'b1;
            end else if (acc1) begin
                rsp_valid <= 1'b1;
                rsp_r     <= shf_r;
                rsp_id    <= 1'b1;
                rsp_tag   <= req1_tag;
                prio      <= 1'b0;
            end else begin
                // Drain only; payload fields keep their last values.
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: directed table, hand-written corner sequences and
// a randomized run against a behavioural model of the arbitration rules.
module tb_shift_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_type;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_type;
    logic [3:0]  req1_tag;
    logic [31:0] shf_a;
    logic [4:0]  shf_shamt;
    logic [1:0]  shf_type;
    logic [31:0] shf_r;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_r;
    logic        rsp_id;
    logic [3:0]  rsp_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_arbiter #(.WIDTH(32), .SHW(5), .TAGW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_shamt(req0_shamt), .req0_type(req0_type), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_shamt(req1_shamt), .req1_type(req1_type), .req1_tag(req1_tag),
        .shf_a(shf_a), .shf_shamt(shf_shamt), .shf_type(shf_type), .shf_r(shf_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] s, logic [1:0] t);
        case (t)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return 32'h0;
        endcase
    endfunction

    // External shared shifter
    always_comb shf_r = ref_shift(shf_a, shf_shamt, shf_type);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = 0; req0_shamt = 0; req0_type = 0; req0_tag = 0;
        req1_valid = 0; req1_a = 0; req1_shamt = 0; req1_type = 0; req1_tag = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        v0; logic [31:0] a0; logic [4:0] s0; logic [1:0] t0; logic [3:0] g0;
        logic        v1; logic [31:0] a1; logic [4:0] s1; logic [1:0] t1; logic [3:0] g1;
        logic [31:0] er; logic        eid; logic [3:0] etag;
    } vec_t;

    vec_t tbl[8];

    // Random-phase model state
    logic        m_valid, m_id, m_prio;
    logic [31:0] m_r;
    logic [3:0]  m_tag;

    initial begin
        tbl[0] = '{1'b1, 32'h8000_0001, 5'd4,  2'b00, 4'h3, 1'b0, 32'h0,         5'd0,  2'b00, 4'h0, 32'h0000_0010, 1'b0, 4'h3};
        tbl[1] = '{1'b0, 32'h0,         5'd0,  2'b00, 4'h0, 1'b1, 32'h8000_0000, 5'd31, 2'b10, 4'hA, 32'hFFFF_FFFF, 1'b1, 4'hA};
        tbl[2] = '{1'b0, 32'h0,         5'd0,  2'b00, 4'h0, 1'b1, 32'h8000_0000, 5'd31, 2'b01, 4'h5, 32'h0000_0001, 1'b1, 4'h5};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 5'd0,  2'b11, 4'h7, 1'b0, 32'h0,         5'd0,  2'b00, 4'h0, 32'h0000_0000, 1'b0, 4'h7};
        // prio is now 1: the tie goes to requester 1, then back to 0
        tbl[4] = '{1'b1, 32'h0000_0001, 5'd1,  2'b00, 4'h1, 1'b1, 32'h0000_00F0, 5'd4,  2'b01, 4'h2, 32'h0000_000F, 1'b1, 4'h2};
        tbl[5] = '{1'b1, 32'h0000_0001, 5'd1,  2'b00, 4'h1, 1'b1, 32'h0000_00F0, 5'd4,  2'b01, 4'h2, 32'h0000_0002, 1'b0, 4'h1};
        tbl[6] = '{1'b1, 32'h1234_5678, 5'd8,  2'b10, 4'hC, 1'b0, 32'h0,         5'd0,  2'b00, 4'h0, 32'h0012_3456, 1'b0, 4'hC};
        tbl[7] = '{1'b0, 32'h0,         5'd0,  2'b00, 4'h0, 1'b1, 32'h8765_4321, 5'd16, 2'b10, 4'hF, 32'hFFFF_8765, 1'b1, 4'hF};

        idle_inputs();
        rsp_ready = 1'b1;
        do_reset();

        // Reset state and idle shifter drive
        @(negedge clk);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 0);
        chk("reset rsp_r", rsp_r, 0);
        chk("reset rsp_id", {31'b0, rsp_id}, 0);
        chk("reset rsp_tag", {28'b0, rsp_tag}, 0);
        chk("idle shf_a", shf_a, 0);
        chk("idle shf_shamt", {27'b0, shf_shamt}, 0);
        chk("idle shf_type", {30'b0, shf_type}, 0);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_shamt = tbl[i].s0;
            req0_type = tbl[i].t0;  req0_tag = tbl[i].g0;
            req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_shamt = tbl[i].s1;
            req1_type = tbl[i].t1;  req1_tag = tbl[i].g1;
            @(negedge clk);
            chk($sformatf("tbl%0d ready0", i), {31'b0, req0_ready}, {31'b0, tbl[i].eid == 1'b0});
            chk($sformatf("tbl%0d ready1", i), {31'b0, req1_ready}, {31'b0, tbl[i].eid == 1'b1});
            @(posedge clk); #1;
            idle_inputs();
            chk($sformatf("tbl%0d rsp_valid", i), {31'b0, rsp_valid}, 1);
            chk($sformatf("tbl%0d rsp_r", i), rsp_r, tbl[i].er);
            chk($sformatf("tbl%0d rsp_id", i), {31'b0, rsp_id}, {31'b0, tbl[i].eid});
            chk($sformatf("tbl%0d rsp_tag", i), {28'b0, rsp_tag}, {28'b0, tbl[i].etag});
        end

        // Drain without refill keeps payload
        @(posedge clk); #1;
        chk("drain rsp_valid", {31'b0, rsp_valid}, 0);
        chk("drain rsp_r held", rsp_r, 32'hFFFF_8765);
        chk("drain rsp_tag held", {28'b0, rsp_tag}, 32'hF);

        // Continuous tie after reset alternates 0,1,0,1...
        do_reset();
        req0_valid = 1; req0_a = 32'h1; req0_shamt = 5'd3; req0_type = 2'b00; req0_tag = 4'h6;
        req1_valid = 1; req1_a = 32'h80; req1_shamt = 5'd3; req1_type = 2'b01; req1_tag = 4'h9;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d rsp_valid", j), {31'b0, rsp_valid}, 1);
            chk($sformatf("rr%0d rsp_id", j), {31'b0, rsp_id}, j % 2);
            chk($sformatf("rr%0d rsp_r", j), rsp_r, (j % 2 == 0) ? 32'h8 : 32'h10);
        end
        idle_inputs();

        // Backpressure with both requesters waiting
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1; req0_a = 32'h3;   req0_shamt = 5'd1; req0_type = 2'b00; req0_tag = 4'h1;
        req1_valid = 1; req1_a = 32'h100; req1_shamt = 5'd4; req1_type = 2'b01; req1_tag = 4'h2;
        @(negedge clk);
        chk("bp first ready0", {31'b0, req0_ready}, 1);
        @(posedge clk); #1;
        req0_a = 32'h5; req0_shamt = 5'd2; req0_tag = 4'h3;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("bp%0d ready0", j), {31'b0, req0_ready}, 0);
            chk($sformatf("bp%0d ready1", j), {31'b0, req1_ready}, 0);
            chk($sformatf("bp%0d rsp_valid", j), {31'b0, rsp_valid}, 1);
            chk($sformatf("bp%0d rsp_r", j), rsp_r, 32'h6);
            chk($sformatf("bp%0d rsp_tag", j), {28'b0, rsp_tag}, 32'h1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release ready1", {31'b0, req1_ready}, 1);
        chk("bp release ready0", {31'b0, req0_ready}, 0);
        @(posedge clk); #1;
        chk("bp refill rsp_r", rsp_r, 32'h10);
        chk("bp refill rsp_id", {31'b0, rsp_id}, 1);
        req1_valid = 0;
        @(negedge clk);
        chk("bp pending ready0", {31'b0, req0_ready}, 1);
        @(posedge clk); #1;
        chk("bp pending rsp_r", rsp_r, 32'h14);
        chk("bp pending rsp_tag", {28'b0, rsp_tag}, 32'h3);
        idle_inputs();

        // Async reset mid-cycle while holding a response
        req0_valid = 1; req0_a = 32'hF; req0_shamt = 5'd4; req0_type = 2'b00; req0_tag = 4'hB;
        @(posedge clk); #1;
        idle_inputs();
        chk("pre-rst rsp_valid", {31'b0, rsp_valid}, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst rsp_valid", {31'b0, rsp_valid}, 0);
        chk("async rst rsp_r", rsp_r, 0);
        chk("async rst rsp_tag", {28'b0, rsp_tag}, 0);
        @(posedge clk); #1 rst = 1'b0;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("post-rst tie ready0", {31'b0, req0_ready}, 1);
        chk("post-rst tie ready1", {31'b0, req1_ready}, 0);
        @(posedge clk); #1;
        idle_inputs();

        // Randomized run against the model
        do_reset();
        m_valid = 0; m_r = 0; m_id = 0; m_tag = 0; m_prio = 0;
        for (int c = 0; c < 3000; c++) begin
            logic acc0, acc1, ca;
            int w;
            if (!req0_valid && ($urandom % 3 != 0)) begin
                req0_valid = 1; req0_a = $urandom; req0_shamt = 5'($urandom);
                req0_type = 2'($urandom); req0_tag = 4'($urandom);
            end
            if (!req1_valid && ($urandom % 3 != 0)) begin
                req1_valid = 1; req1_a = $urandom; req1_shamt = 5'($urandom);
                req1_type = 2'($urandom); req1_tag = 4'($urandom);
            end
            rsp_ready = ($urandom % 4 != 0);
            @(negedge clk);
            chk("rnd rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
            chk("rnd rsp_r", rsp_r, m_r);
            chk("rnd rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
            chk("rnd rsp_tag", {28'b0, rsp_tag}, {28'b0, m_tag});
            ca = !m_valid || rsp_ready;
            if (req0_valid && req1_valid) w = m_prio ? 1 : 0;
            else if (req0_valid) w = 0;
            else if (req1_valid) w = 1;
            else w = -1;
            acc0 = ca && (w == 0);
            acc1 = ca && (w == 1);
            chk("rnd ready0", {31'b0, req0_ready}, {31'b0, acc0});
            chk("rnd ready1", {31'b0, req1_ready}, {31'b0, acc1});
            if (ca) begin
                if (w == 0) begin
                    m_valid = 1; m_r = ref_shift(req0_a, req0_shamt, req0_type);
                    m_id = 0; m_tag = req0_tag; m_prio = 1;
                end else if (w == 1) begin
                    m_valid = 1; m_r = ref_shift(req1_a, req1_shamt, req1_type);
                    m_id = 1; m_tag = req1_tag; m_prio = 0;
                end else begin
                    m_valid = 0;
                end
            end
            @(posedge clk); #1;
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
